// File: rtl/imem_loader.sv
// Instruction memory loader: assembles a framed little-endian byte stream into
// 32-bit instruction writes and holds the CPU until a checksum-verified image is resident.
module imem_loader #(
  parameter int DEPTH  = 128,
  parameter int ADDR_W = 7
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic              we,
  output logic [ADDR_W-1:0] waddr,
  output logic [31:0]       wdata,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic              cpu_hold,
  output logic [15:0]       words_loaded
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LEN0  = 3'd1,
    ST_LEN1  = 3'd2,
    ST_DATA  = 3'd3,
    ST_WRITE = 3'd4,
    ST_CHECK = 3'd5,
    ST_DONE  = 3'd6,
    ST_ERR   = 3'd7
  } state_t;

  localparam logic [15:0]       DEPTH_W   = 16'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  state_t            state_r;
  state_t            state_s;
  logic [15:0]       len_r;
  logic [1:0]        idx_r;
  logic [7:0]        chk_r;
  logic [ADDR_W-1:0] waddr_r;
  logic [31:0]       wdata_r;
  logic [15:0]       words_r;
  logic              rx_ready_r;
  logic              we_r;
  logic              busy_r;
  logic              done_r;
  logic              error_r;
  logic              cpu_hold_r;
  logic              accept_s;
  logic [15:0]       len_full_s;

  function automatic logic [7:0] chk_fold(input logic [7:0] acc, input logic [7:0] b);
    return acc ^ b;
  endfunction

  assign accept_s   = rx_valid && rx_ready_r;
  assign len_full_s = {rx_data, len_r[7:0]};

  // Next-state decode of the frame parser.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE, ST_DONE, ST_ERR: begin
        if (start) state_s = ST_LEN0;
        else       state_s = state_r;
      end
      ST_LEN0: begin
        if (accept_s) state_s = ST_LEN1;
        else          state_s = ST_LEN0;
      end
      ST_LEN1: begin
        if (accept_s) begin
          if (len_full_s == 16'd0)        state_s = ST_CHECK;
          else if (len_full_s > DEPTH_W)  state_s = ST_ERR;
          else                            state_s = ST_DATA;
        end else begin
          state_s = ST_LEN1;
        end
      end
      ST_DATA: begin
        if (accept_s && (idx_r == 2'd3)) state_s = ST_WRITE;
        else                             state_s = ST_DATA;
      end
      ST_WRITE: begin
        if ((words_r + 16'd1) == len_r) state_s = ST_CHECK;
        else                            state_s = ST_DATA;
      end
      ST_CHECK: begin
        if (accept_s) begin
          if (rx_data == chk_r) state_s = ST_DONE;
          else                  state_s = ST_ERR;
        end else begin
          state_s = ST_CHECK;
        end
      end
      default: state_s = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_r <= ST_IDLE;
    else     state_r <= state_s;
  end

  // Status/handshake outputs are registered decodes of the upcoming state.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_ready_r <= 1'b0;
      we_r       <= 1'b0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      error_r    <= 1'b0;
      cpu_hold_r <= 1'b1;
    end else begin
      rx_ready_r <= (state_s == ST_LEN0) || (state_s == ST_LEN1) ||
                    (state_s == ST_DATA) || (state_s == ST_CHECK);
      we_r       <= (state_s == ST_WRITE);
      busy_r     <= (state_s == ST_LEN0) || (state_s == ST_LEN1) || (state_s == ST_DATA) ||
                    (state_s == ST_WRITE) || (state_s == ST_CHECK);
      done_r     <= (state_s == ST_DONE);
      error_r    <= (state_s == ST_ERR);
      cpu_hold_r <= (state_s != ST_DONE);
    end
  end

  // Length capture, word assembly, checksum and write address/count tracking.
  always_ff @(posedge clk) begin
    if (rst) begin
      len_r   <= 16'd0;
      idx_r   <= 2'd0;
      chk_r   <= 8'd0;
      waddr_r <= '0;
      wdata_r <= 32'd0;
      words_r <= 16'd0;
    end else begin
      case (state_r)
        ST_IDLE, ST_DONE, ST_ERR: begin
          if (start) begin
            len_r   <= 16'd0;
            idx_r   <= 2'd0;
            chk_r   <= 8'd0;
            waddr_r <= '0;
            words_r <= 16'd0;
          end
        end
        ST_LEN0: if (accept_s) len_r[7:0]  <= rx_data;
        ST_LEN1: if (accept_s) len_r[15:8] <= rx_data;
        ST_DATA: begin
          if (accept_s) begin
            wdata_r[{idx_r, 3'b000} +: 8] <= rx_data;
            chk_r <= chk_fold(chk_r, rx_data);
            idx_r <= idx_r + 2'd1;
          end
        end
        ST_WRITE: begin
          // Saturate so the address never points past the last memory word.
          if (waddr_r != LAST_ADDR) waddr_r <= waddr_r + ADDR_W'(1);
          words_r <= words_r + 16'd1;
          idx_r   <= 2'd0;
        end
        default: ;
      endcase
    end
  end

  assign rx_ready     = rx_ready_r;
  assign we           = we_r;
  assign waddr        = waddr_r;
  assign wdata        = wdata_r;
  assign busy         = busy_r;
  assign done         = done_r;
  assign error        = error_r;
  assign cpu_hold     = cpu_hold_r;
  assign words_loaded = words_r;

endmodule
